s5378_cone_scan_ctrl: RTL and testbench

Scan-style pattern controller for the extracted s5378 combinational cones, such as the partial-output cone producing `n514`. It holds the cone's 29 pseudo-primary inputs in a register bank, loads a pattern serially from the test host, waits a programmable settle time, then captures the cone output. It compares the captured bit against an expected value and keeps pass/fail statistics. It sits between the host pattern source and one combinational cone instance.

---
 rtl/s5378_cone_scan_ctrl_pkg.sv | 18 +
 rtl/s5378_cone_scan_ctrl_if.sv | 31 +++
 rtl/s5378_cone_scan_ctrl_shift_reg.sv | 20 ++
 rtl/s5378_cone_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_s5378_cone_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/s5378_cone_scan_ctrl_pkg.sv
// Shared state encoding and default sizing for the s5378 cone scan controller.
package cone_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int N_IN_DEF       = 29;
  localparam int SETTLE_CYC_DEF = 2;
  localparam int CNT_W_DEF      = 16;

  // pi bit positions of the cone pins; intermediate indices follow cone port order
  localparam int PIN_N3065GAT = 0;
  localparam int PIN_N3095GAT = 28;

endpackage

// File: rtl/s5378_cone_scan_ctrl_if.sv
// Host-side pattern/handshake/statistics bundle of the cone scan controller.
interface s5378_cone_scan_ctrl_if
  import cone_scan_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic             exp_in;
  logic             si;
  logic             si_valid;
  logic             si_ready;
  logic             clear;
  logic             busy;
  logic             done;
  logic             resp;
  logic             mismatch;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output start, exp_in, si, si_valid, clear,
    input  si_ready, busy, done, resp, mismatch, pat_cnt, fail_cnt
  );

  modport slave (
    input  start, exp_in, si, si_valid, clear,
    output si_ready, busy, done, resp, mismatch, pat_cnt, fail_cnt
  );

endinterface

// File: rtl/s5378_cone_scan_ctrl_shift_reg.sv
// Pattern register: LSB-first serial load into the cone input bank.
module scan_shift_reg #(
  parameter int N_IN = 29
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic            din,
  output logic [N_IN-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[N_IN-1:1]};
    end
  end

endmodule

// File: rtl/s5378_cone_scan_ctrl.sv
// Scan pattern controller: serial load, settle, capture and compare one cone output.
module s5378_cone_scan_ctrl
  import cone_scan_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                   CK,
  input  logic                   RST,
  s5378_cone_scan_ctrl_if.slave  bus,
  output logic [N_IN-1:0]        pi,
  input  logic                   cone_out
);

  localparam int BIT_W = $clog2(N_IN + 1);

  state_t           state;
  state_t           state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [3:0]       settle_cnt;
  logic             exp_q;
  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             capture;
  logic             busy;
  logic             si_ready;
  logic             resp_q;
  logic             done_q;
  logic             mism_q;
  logic [CNT_W-1:0] pat_q;
  logic [CNT_W-1:0] fail_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (shift_en && last_bit) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 4'd1) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    si_ready = (state == ST_SHIFT);
    accept   = (state == ST_IDLE) && bus.start;
    shift_en = si_ready && bus.si_valid;
    last_bit = (bit_cnt == BIT_W'(N_IN - 1));
    capture  = (state == ST_SETTLE) && (settle_cnt == 4'd1);
  end

  // Stage: serial load of the cone input bank
  scan_shift_reg #(
    .N_IN (N_IN)
  ) u_shift (
    .clk (CK),
    .clr (RST),
    .en  (shift_en),
    .din (bus.si),
    .q   (pi)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      bit_cnt    <= '0;
      settle_cnt <= '0;
      exp_q      <= 1'b0;
    end else begin
      if (accept) begin
        bit_cnt <= '0;
        exp_q   <= bus.exp_in;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (shift_en && last_bit) begin
        settle_cnt <= 4'(SETTLE_CYC);
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  // Stage: capture and compare after the settle window
  always_ff @(posedge CK) begin
    if (RST) begin
      resp_q <= 1'b0;
      done_q <= 1'b0;
      mism_q <= 1'b0;
    end else begin
      done_q <= capture;
      mism_q <= capture && (cone_out ^ exp_q);
      if (capture) begin
        resp_q <= cone_out;
      end
    end
  end

  // clear wins over a coinciding capture, so that pattern goes uncounted
  always_ff @(posedge CK) begin
    if (RST || bus.clear) begin
      pat_q  <= '0;
      fail_q <= '0;
    end else if (capture) begin
      pat_q <= pat_q + CNT_W'(1);
      if (cone_out ^ exp_q) begin
        fail_q <= sat_inc(fail_q);
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.si_ready = si_ready;
  assign bus.done     = done_q;
  assign bus.resp     = resp_q;
  assign bus.mismatch = mism_q;
  assign bus.pat_cnt  = pat_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_s5378_cone_scan_ctrl.sv
// Scoreboard bench for the cone scan controller with a stub cone and randomized patterns.
module tb_s5378_cone_scan_ctrl;
  import cone_scan_pkg::*;

  localparam int N_IN       = 29;
  localparam int SETTLE_CYC = 2;
  localparam int CNT_W      = 4;

  logic            CK = 1'b0;
  logic            RST = 1'b1;
  logic [N_IN-1:0] pi;
  logic            cone_out;

  s5378_cone_scan_ctrl_if #(.CNT_W(CNT_W)) bus ();

  s5378_cone_scan_ctrl #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .bus      (bus.slave),
    .pi       (pi),
    .cone_out (cone_out)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // Stub cone: 0 = pi[0], 1 = parity of masked bits, 2 = single selected bit
  int              cone_mode = 0;
  logic [N_IN-1:0] cone_mask = '0;
  int              cone_bit  = 0;

  always_comb begin
    case (cone_mode)
      0:       cone_out = pi[0];
      1:       cone_out = ^(pi & cone_mask);
      default: cone_out = pi[cone_bit];
    endcase
  end

  function automatic logic cone_ref(input logic [N_IN-1:0] v);
    case (cone_mode)
      0:       return v[0];
      1:       return ^(v & cone_mask);
      default: return v[cone_bit];
    endcase
  endfunction

  typedef struct {
    logic             resp;
    logic             mism;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] fc;
    logic [N_IN-1:0]  pat;
    int               cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;

  int tests = 0;
  int fails = 0;

  logic [CNT_W-1:0] m_pat    = '0;
  logic [CNT_W-1:0] m_fail   = '0;
  logic [N_IN-1:0]  last_pat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge CK) begin
    if (!RST) begin
      if (!bus.done) begin
        chk("mismatch_without_done", 64'(bus.mismatch), 64'(0));
      end else if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        ex = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(ex.cyc));
        chk("resp", 64'(bus.resp), 64'(ex.resp));
        chk("mismatch", 64'(bus.mismatch), 64'(ex.mism));
        chk("pat_cnt", 64'(bus.pat_cnt), 64'(ex.pc));
        chk("fail_cnt", 64'(bus.fail_cnt), 64'(ex.fc));
        chk("pi_at_done", 64'(pi), 64'(ex.pat));
        chk("busy_at_done", 64'(bus.busy), 64'(0));
      end
    end
  end

  task automatic tick();
    logic c;
    c = bus.clear;
    @(posedge CK);
    #1;
    if (c) begin
      m_pat  = '0;
      m_fail = '0;
    end
  endtask

  task automatic noise_drive();
    bus.start  = 1'($urandom);
    bus.exp_in = 1'($urandom);
    bus.clear  = ($urandom_range(0, 19) == 0);
  endtask

  task automatic run_pattern(input logic [N_IN-1:0] pat, input logic e, input int gap_mode,
                             input bit noise, input bit clr_cap);
    int   tl;
    int   g;
    logic r;
    bus.start  = 1'b1;
    bus.exp_in = e;
    tick();
    bus.start  = 1'b0;
    bus.exp_in = ~e;
    chk("pi_hold_at_start", 64'(pi), 64'(last_pat));
    chk("busy_in_shift", 64'(bus.busy), 64'(1));
    chk("si_ready_in_shift", 64'(bus.si_ready), 64'(1));
    for (int i = 0; i < N_IN; i++) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        bus.si_valid = 1'b0;
        bus.si       = 1'($urandom);
        if (noise) noise_drive();
        tick();
        bus.clear = 1'b0;
      end
      bus.si_valid = 1'b1;
      bus.si       = pat[i];
      if (noise) noise_drive();
      tick();
      bus.clear = 1'b0;
    end
    tl = cyc;
    bus.si_valid = 1'b0;
    for (int k = 1; k <= SETTLE_CYC; k++) begin
      if (noise) begin
        bus.si_valid = 1'($urandom);
        bus.si       = 1'($urandom);
        bus.start    = 1'($urandom);
      end
      bus.clear = (k == SETTLE_CYC) ? clr_cap : (noise && $urandom_range(0, 9) == 0);
      tick();
      bus.clear = 1'b0;
    end
    bus.start    = 1'b0;
    bus.si_valid = 1'b0;
    r = cone_ref(pat);
    if (!clr_cap) begin
      m_pat = m_pat + 1'b1;
      if ((r ^ e) && (m_fail != '1)) m_fail = m_fail + 1'b1;
    end
    sbq.push_back('{r, r ^ e, m_pat, m_fail, pat, tl + SETTLE_CYC});
    last_pat = pat;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      bus.si_valid = 1'($urandom);
      bus.si       = 1'($urandom);
      tick();
    end
    bus.si_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN-1:0] pat;
    bus.start    = 1'b0;
    bus.exp_in   = 1'b0;
    bus.si       = 1'b0;
    bus.si_valid = 1'b0;
    bus.clear    = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_si_ready", 64'(bus.si_ready), 64'(0));
    chk("rst_pi", 64'(pi), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_resp", 64'(bus.resp), 64'(0));
    chk("rst_pat_cnt", 64'(bus.pat_cnt), 64'(0));
    chk("rst_fail_cnt", 64'(bus.fail_cnt), 64'(0));

    // All-zero pattern through a parity cone, no gaps
    cone_mode = 1;
    cone_mask = N_IN'($urandom);
    run_pattern('0, 1'b0, 0, 1'b0, 1'b0);
    idle_gap(2);

    // pi[0] stub, single-one pattern, expect 0 -> mismatch
    cone_mode = 0;
    run_pattern(N_IN'(1), 1'b0, 0, 1'b0, 1'b0);
    idle_gap(1);

    // Alternating si_valid stalls the load by one cycle per bit
    run_pattern(N_IN'(29'h0A5A_5A5B), 1'b1, 1, 1'b0, 1'b0);

    // Back-to-back at minimum period, with ignored start/si_valid noise
    run_pattern(N_IN'($urandom), 1'($urandom), 0, 1'b1, 1'b0);
    idle_gap(2);

    // Reset in the middle of the load
    bus.start  = 1'b1;
    bus.exp_in = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.si_valid = 1'b1;
      bus.si       = 1'($urandom);
      tick();
    end
    bus.si_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_pat    = '0;
    m_fail   = '0;
    last_pat = '0;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_si_ready", 64'(bus.si_ready), 64'(0));
    chk("midrst_pi", 64'(pi), 64'(0));
    chk("midrst_pat_cnt", 64'(bus.pat_cnt), 64'(0));
    chk("midrst_fail_cnt", 64'(bus.fail_cnt), 64'(0));
    run_pattern(N_IN'($urandom), 1'($urandom), 2, 1'b0, 1'b0);
    idle_gap(1);

    // Drive fail_cnt into saturation; pat_cnt wraps meanwhile
    cone_mode = 0;
    for (int n = 0; n < 18; n++) begin
      pat = N_IN'($urandom) | N_IN'(1);
      run_pattern(pat, 1'b0, 0, 1'b0, 1'b0);
    end
    chk("fail_cnt_saturated", 64'(bus.fail_cnt), 64'({CNT_W{1'b1}}));
    idle_gap(1);

    // clear landing on the capture edge
    run_pattern(N_IN'($urandom), 1'($urandom), 0, 1'b0, 1'b1);
    chk("clear_at_capture_pat_cnt", 64'(bus.pat_cnt), 64'(0));
    chk("clear_at_capture_fail_cnt", 64'(bus.fail_cnt), 64'(0));
    idle_gap(1);

    // Randomized patterns, cones, stalls and noise
    for (int n = 0; n < 25; n++) begin
      cone_mode = $urandom_range(0, 2);
      cone_mask = N_IN'($urandom);
      cone_bit  = $urandom_range(0, N_IN - 1);
      run_pattern(N_IN'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b1,
                  ($urandom_range(0, 7) == 0));
      idle_gap($urandom_range(0, 2));
    end

    for (int w = 0; w < 50 && sbq.size() > 0; w++) tick();
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected responses never appeared, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
